// File: rtl/cycle_gen_ip.sv
// ---------------------------------------------------------------------------
// cycle_gen_ip
//   Avalon-MM slave that generates a programmable periodic rectangular wave.
//   The host programs PERIOD and HIGH in csi_clk cycles; the waveform drives
//   the period-measurement path for self-test and calibration.
//
//   Optional feature macro: CYCLE_GEN_BURST_EN
//     defined   -> BURST register (addr 4): run stops by itself after BURST
//                  periods, setting STATUS.DONE and clearing CTRL.EN.
//     undefined -> addr 4 reads 0, writes ignored, DONE always 0.
//
// Ports
//   csi_clk         clock, all registers on rising edge
//   csi_reset       asynchronous active-high reset
//   avs_chipselect  slave select
//   avs_address     word address: 0 PERIOD, 1 HIGH, 2 CTRL, 3 CYCLES,
//                   4 BURST, 5 STATUS, 6/7 reserved (read 0)
//   avs_write       write strobe (qualified by chipselect)
//   avs_writedata   write data (only CNT_W LSBs stored)
//   avs_read        read strobe (qualified by chipselect)
//   avs_readdata    combinational read data, 0 when not reading
//   coe_S_out       generated waveform (registered)
// ---------------------------------------------------------------------------
module cycle_gen_ip #(
    parameter int CNT_W      = 32,
    parameter int RST_PERIOD = 100,
    parameter int RST_HIGH   = 50
) (
    input  logic        csi_clk,
    input  logic        csi_reset,
    input  logic        avs_chipselect,
    input  logic [2:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        coe_S_out
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    // host registers
    logic [CNT_W-1:0] period_r, high_r, cycles_r;
    logic             en_r, done_r;

    // generator state
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] per_sh, hi_sh;
    logic             out_nx;
    logic             load_sh, start, cyc_inc, burst_fin;

    logic [CNT_W-1:0] wdat;
    logic             wr_en, wr_per, wr_high, wr_ctrl, wr_cyc;

    assign wdat    = avs_writedata[CNT_W-1:0];
    assign wr_en   = avs_chipselect & avs_write;
    assign wr_per  = wr_en && (avs_address == 3'd0);
    assign wr_high = wr_en && (avs_address == 3'd1);
    assign wr_ctrl = wr_en && (avs_address == 3'd2);
    assign wr_cyc  = wr_en && (avs_address == 3'd3);

`ifdef CYCLE_GEN_BURST_EN
    logic [CNT_W-1:0] burst_r, burst_sh, bcnt;
    logic             wr_burst;
    assign wr_burst = wr_en && (avs_address == 3'd4);
`endif

    // ---------------- next-state / output logic ----------------
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        out_nx    = coe_S_out;
        load_sh   = 1'b0;
        start     = 1'b0;
        cyc_inc   = 1'b0;
        burst_fin = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                out_nx = 1'b0;
                if (en_r) begin
                    state_nx = S_RUN;
                    load_sh  = 1'b1;
                    start    = 1'b1;
                    // first output level uses the freshly loaded shadows
                    out_nx   = (period_r >= TWO) && (high_r != '0);
                end
            end
            S_RUN: begin
                if (!en_r) begin
                    // immediate stop; the partial period is dropped
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                    out_nx   = 1'b0;
                end else if (per_sh < TWO) begin
                    // degenerate period: hold low, keep polling PERIOD/HIGH
                    load_sh = 1'b1;
                    cnt_nx  = '0;
                    out_nx  = 1'b0;
                end else if (cnt == per_sh - ONE) begin
                    cnt_nx  = '0;
                    load_sh = 1'b1;
                    cyc_inc = 1'b1;
                    out_nx  = (period_r >= TWO) && (high_r != '0);
`ifdef CYCLE_GEN_BURST_EN
                    if ((burst_sh != '0) && (bcnt + ONE == burst_sh)) begin
                        burst_fin = 1'b1;
                        state_nx  = S_IDLE;
                        out_nx    = 1'b0;
                    end
`endif
                end else begin
                    cnt_nx = cnt + ONE;
                    out_nx = (cnt + ONE) < hi_sh;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ---------------- generator registers ----------------
    always_ff @(posedge csi_clk or posedge csi_reset) begin
        if (csi_reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            per_sh    <= '0;
            hi_sh     <= '0;
            coe_S_out <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            coe_S_out <= out_nx;
            if (load_sh) begin
                per_sh <= period_r;
                hi_sh  <= high_r;
            end
        end
    end

    // ---------------- host registers ----------------
    always_ff @(posedge csi_clk or posedge csi_reset) begin
        if (csi_reset) begin
            period_r <= CNT_W'(RST_PERIOD);
            high_r   <= CNT_W'(RST_HIGH);
            en_r     <= 1'b0;
            cycles_r <= '0;
        end else begin
            if (wr_per)  period_r <= wdat;
            if (wr_high) high_r   <= wdat;
            // host write beats the automatic burst stop
            if (wr_ctrl)        en_r <= wdat[0];
            else if (burst_fin) en_r <= 1'b0;
            // write-clear beats a same-edge increment
            if (wr_cyc)       cycles_r <= '0;
            else if (cyc_inc) cycles_r <= cycles_r + ONE;
        end
    end

`ifdef CYCLE_GEN_BURST_EN
    always_ff @(posedge csi_clk or posedge csi_reset) begin
        if (csi_reset) begin
            burst_r  <= '0;
            burst_sh <= '0;
            bcnt     <= '0;
            done_r   <= 1'b0;
        end else begin
            if (wr_burst) burst_r <= wdat;
            // burst length and progress are latched per run
            if (start) begin
                burst_sh <= burst_r;
                bcnt     <= '0;
            end else if (cyc_inc) begin
                bcnt <= bcnt + ONE;
            end
            if (wr_ctrl)        done_r <= 1'b0;
            else if (burst_fin) done_r <= 1'b1;
        end
    end
`else
    assign done_r = 1'b0;
`endif

    // ---------------- read mux ----------------
    always_comb begin
        avs_readdata = '0;
        if (avs_chipselect && avs_read) begin
            case (avs_address)
                3'd0: avs_readdata = 32'(period_r);
                3'd1: avs_readdata = 32'(high_r);
                3'd2: avs_readdata = {31'd0, en_r};
                3'd3: avs_readdata = 32'(cycles_r);
`ifdef CYCLE_GEN_BURST_EN
                3'd4: avs_readdata = 32'(burst_r);
`endif
                3'd5: avs_readdata = {30'd0, done_r, state == S_RUN};
                default: avs_readdata = '0;
            endcase
        end
    end

endmodule
